// File: rtl/freq_div_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// freq_div_pkg : shared constants, index-width helper and channel state layout
// Rev 1.0
// ----------------------------------------------------------------------------
package freq_div_pkg;

  localparam int CNT_W_DEF = 26;
  localparam int DIV_HALT  = 0;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reference layout at the default width; channels build the same shape at CNT_W.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] cnt;
    logic [CNT_W_DEF-1:0] act_div;
    logic [CNT_W_DEF-1:0] pend_div;
    logic                 pend_flag;
  } ch_state_t;

endpackage
`default_nettype wire

// File: rtl/freq_div_multi_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// freq_div_multi_if : divisor configuration write channel (valid/ready)
// Rev 1.0
// ----------------------------------------------------------------------------
interface freq_div_multi_if
  import freq_div_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = CNT_W_DEF
);
  localparam int CH_W = ch_idx_w(N_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_now;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_now, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_now, output cfg_ready);

endinterface
`default_nettype wire

// File: rtl/freq_div_ch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// freq_div_ch : one divider channel (counter, shadow divisor, registered outputs)
// Rev 1.0
// ----------------------------------------------------------------------------
module freq_div_ch
  import freq_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = 100000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic             now_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] pend_div;
    logic             pend_flag;
  } ch_st_t;

  ch_st_t st_q, st_d;
  logic   armed_q, armed_d;
  logic   clk_q, clk_d;
  logic   tick_q, tick_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W:0]   hi_len;

  assign cnt_inc  = st_q.cnt + CNT_W'(1);
  assign last_cnt = st_q.act_div - CNT_W'(1);
  assign hi_len   = ({1'b0, st_q.act_div} + (CNT_W+1)'(1)) >> 1;

  always_comb begin
    st_d    = st_q;
    armed_d = armed_q;
    clk_d   = clk_q;
    tick_d  = tick_q;
    if (clr_i) begin
      st_d.cnt       = '0;
      st_d.pend_flag = 1'b0;
      clk_d          = 1'b0;
      tick_d         = 1'b0;
      armed_d        = 1'b0;
      if (wr_i)                st_d.act_div = div_i;
      else if (st_q.pend_flag) st_d.act_div = st_q.pend_div;
    end else if (wr_i && now_i) begin
      st_d.act_div   = div_i;
      st_d.cnt       = '0;
      st_d.pend_flag = 1'b0;
      clk_d          = 1'b0;
      tick_d         = 1'b0;
      armed_d        = 1'b0;
    end else begin
      // A halted channel has no boundary to wait for, so a pending divisor lands now.
      if (!en_i || st_q.act_div == CNT_W'(DIV_HALT)) begin
        st_d.cnt = '0;
        clk_d    = 1'b0;
        tick_d   = 1'b0;
        armed_d  = 1'b0;
        if (st_q.pend_flag) begin
          st_d.act_div   = st_q.pend_div;
          st_d.pend_flag = 1'b0;
        end
      end else if (st_q.cnt == last_cnt) begin
        st_d.cnt = '0;
        clk_d    = 1'b1;
        tick_d   = 1'b1;
        armed_d  = 1'b1;
        if (st_q.pend_flag) begin
          st_d.act_div   = st_q.pend_div;
          st_d.pend_flag = 1'b0;
        end
      end else begin
        st_d.cnt = cnt_inc;
        tick_d   = 1'b0;
        // Until the first wrap clk stays low, so the first rise coincides with the first tick.
        clk_d    = armed_q && ({1'b0, cnt_inc} < hi_len);
      end
      if (wr_i) begin
        st_d.pend_div  = div_i;
        st_d.pend_flag = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q.cnt       <= '0;
      st_q.act_div   <= CNT_W'(DEF_DIV);
      st_q.pend_div  <= '0;
      st_q.pend_flag <= 1'b0;
      armed_q        <= 1'b0;
      clk_q          <= 1'b0;
      tick_q         <= 1'b0;
    end else begin
      st_q    <= st_d;
      armed_q <= armed_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign pend_o = st_q.pend_flag;
  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/freq_div_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// freq_div_multi : N-channel programmable clock divider with runtime reprogramming
// Rev 1.0
// ----------------------------------------------------------------------------
module freq_div_multi
  import freq_div_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = 100000
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     ch_en,
  input  logic                sync_clr,
  freq_div_multi_if.slave     cfg,
  output logic [N_CH-1:0]     clk_out,
  output logic [N_CH-1:0]     tick
);

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] wr_en;
  logic [31:0]     ch_sel;

  assign ch_sel = 32'(cfg.cfg_ch);

  // Out-of-range channel numbers match nothing: ready stays high and the write is dropped.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    wr_en         = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == i) begin
        cfg.cfg_ready = ~pend[i];
        wr_en[i]      = cfg.cfg_valid & ~pend[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    freq_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_i   (clk_in),
      .rst_ni  (rst_n),
      .en_i    (ch_en[g]),
      .clr_i   (sync_clr),
      .wr_i    (wr_en[g]),
      .now_i   (cfg.cfg_now),
      .div_i   (cfg.cfg_div),
      .pend_o  (pend[g]),
      .clk_o   (clk_out[g]),
      .tick_o  (tick[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_div_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_freq_div_multi : table-driven scoreboard bench for freq_div_multi
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_freq_div_multi;
  import freq_div_pkg::*;

  localparam int N_CH    = 3;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 6;
  localparam int K       = 75;
  localparam int CH_W    = ch_idx_w(N_CH);

  logic            clk_in = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] ch_en;
  logic            sync_clr;
  logic [N_CH-1:0] clk_out;
  logic [N_CH-1:0] tick;

  freq_div_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) cfg_if ();

  freq_div_multi #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .ch_en    (ch_en),
    .sync_clr (sync_clr),
    .cfg      (cfg_if.slave),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [N_CH-1:0]  en;
    logic             clr;
    logic             valid;
    logic             now;
    logic             rdy;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] div;
    logic [N_CH-1:0]  exp_clk;
    logic [N_CH-1:0]  exp_tick;
  } vec_t;

  // A segment is a stretch where a channel runs one divisor from a known start edge.
  // Fresh: counter cleared at 'start', first tick D edges later. Armed: 'start' is a wrap.
  typedef struct {
    int ch;
    int start;
    int d;
    bit armed;
  } seg_t;

  vec_t              vecs [1:K];
  seg_t              segs [$];
  logic [2*N_CH-1:0] exp_q [$];
  int                n_cmp = 0;
  int                n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add_seg(input int c, input int s, input int d, input bit a);
    seg_t x;
    x.ch = c; x.start = s; x.d = d; x.armed = a;
    segs.push_back(x);
  endfunction

  function automatic logic [1:0] ch_out(input int c, input int k);
    seg_t s;
    int   m;
    int   ph;
    s.ch = c; s.start = 0; s.d = 0; s.armed = 1'b0;
    foreach (segs[i]) if (segs[i].ch == c && segs[i].start <= k) s = segs[i];
    if (s.d == 0) return 2'b00;
    m = k - s.start;
    if (!s.armed && m < s.d) return 2'b00;
    ph = m % s.d;
    return {ph < (s.d + 1) / 2, ph == 0};
  endfunction

  task automatic apply(input vec_t v);
    ch_en            = v.en;
    sync_clr         = v.clr;
    cfg_if.cfg_valid = v.valid;
    cfg_if.cfg_ch    = v.ch;
    cfg_if.cfg_div   = v.div;
    cfg_if.cfg_now   = v.now;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    ch_en            = 3'b011;
    sync_clr         = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_now   = 1'b0;

    add_seg(0, 0, 6, 0);  add_seg(0, 12, 5, 1); add_seg(0, 24, 0, 0);
    add_seg(0, 28, 2, 0); add_seg(0, 35, 6, 0); add_seg(0, 45, 6, 0);
    add_seg(0, 60, 0, 0); add_seg(0, 63, 4, 0);
    add_seg(1, 0, 6, 0);  add_seg(1, 20, 1, 0); add_seg(1, 34, 3, 0);
    add_seg(1, 45, 4, 0); add_seg(1, 69, 2, 1);
    add_seg(2, 0, 0, 0);

    for (int k = 1; k <= K; k++) begin
      vec_t       v;
      logic [1:0] o;
      v.en    = (k >= 60 && k <= 63) ? 3'b010 : 3'b011;
      v.clr   = 1'b0;
      v.valid = 1'b0;
      v.now   = 1'b0;
      v.rdy   = 1'b1;
      v.ch    = 2'd0;
      v.div   = 8'd0;
      case (k)
        8:              begin v.valid = 1'b1; v.div = 8'd5; end
        9, 12, 62:      v.rdy = 1'b0;
        10:             begin v.valid = 1'b1; v.div = 8'd9; v.now = 1'b1; v.rdy = 1'b0; end
        11, 70:         v.ch = 2'd1;
        20:             begin v.valid = 1'b1; v.ch = 2'd1; v.div = 8'd1; v.now = 1'b1; end
        24:             begin v.valid = 1'b1; v.div = 8'd0; v.now = 1'b1; end
        28:             begin v.valid = 1'b1; v.div = 8'd2; v.now = 1'b1; end
        34:             begin v.valid = 1'b1; v.ch = 2'd1; v.div = 8'd3; v.now = 1'b1; end
        35:             begin v.valid = 1'b1; v.div = 8'd6; v.now = 1'b1; end
        40:             begin v.valid = 1'b1; v.ch = 2'd3; v.div = 8'd1; v.now = 1'b1; end
        45:             begin v.clr = 1'b1; v.valid = 1'b1; v.ch = 2'd1; v.div = 8'd4; end
        61:             begin v.valid = 1'b1; v.div = 8'd4; end
        65:             begin v.valid = 1'b1; v.ch = 2'd1; v.div = 8'd2; end
        66, 67, 68, 69: begin v.ch = 2'd1; v.rdy = 1'b0; end
        default: ;
      endcase
      for (int c = 0; c < N_CH; c++) begin
        o = ch_out(c, k);
        v.exp_clk[c]  = o[1];
        v.exp_tick[c] = o[0];
      end
      vecs[k] = v;
    end

    repeat (3) @(negedge clk_in);
    check("reset clk_out", 32'(clk_out), 32'h0);
    check("reset tick", 32'(tick), 32'h0);
    check("reset cfg_ready", 32'(cfg_if.cfg_ready), 32'h1);
    rst_n = 1'b1;

    for (int k = 1; k <= K; k++) begin
      logic [2*N_CH-1:0] e;
      apply(vecs[k]);
      #1;
      check($sformatf("cfg_ready vec%0d", k), 32'(cfg_if.cfg_ready), 32'(vecs[k].rdy));
      exp_q.push_back({vecs[k].exp_clk, vecs[k].exp_tick});
      @(negedge clk_in);
      e = exp_q.pop_front();
      check($sformatf("clk_out vec%0d", k), 32'(clk_out), 32'(e[2*N_CH-1:N_CH]));
      check($sformatf("tick vec%0d", k), 32'(tick), 32'(e[N_CH-1:0]));
    end

    // Deferred write left pending, then an asynchronous reset mid-cycle.
    apply(vecs[K]);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_div   = 8'd3;
    cfg_if.cfg_now   = 1'b0;
    #1 check("pre-reset cfg_ready", 32'(cfg_if.cfg_ready), 32'h1);
    @(negedge clk_in);
    cfg_if.cfg_valid = 1'b0;
    #1 check("pending cfg_ready", 32'(cfg_if.cfg_ready), 32'h0);
    begin
      int w = 0;
      while (clk_out[1] !== 1'b1 && w < 10) begin
        @(negedge clk_in);
        w++;
      end
      check("clk_out[1] high before reset", 32'(clk_out[1]), 32'h1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async reset clk_out", 32'(clk_out), 32'h0);
    check("async reset tick", 32'(tick), 32'h0);
    check("async reset cfg_ready", 32'(cfg_if.cfg_ready), 32'h1);
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk_in);
      check($sformatf("post-reset tick[0] edge%0d", e), 32'(tick[0]), 32'((e % 6) == 0));
      check($sformatf("post-reset clk_out[0] edge%0d", e), 32'(clk_out[0]),
            32'(e >= 6 && (e % 6) < 3));
    end
    check("post-reset cfg_ready", 32'(cfg_if.cfg_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_div_multi.md
Name: freq_div_multi

Overview:
- Parametrised N-channel programmable clock divider; successor to the fixed single-channel divider.
- Each channel produces a registered divided clock (`clk_out`) plus a one-cycle period strobe (`tick`) from one system clock.
- Supports odd and even divisors, runtime reprogramming (deferred or immediate), per-channel enable, and a global phase-align clear.
- Feeds SRAM controller timing and other slow-clock consumers in the same clock domain.

Parameters:
- N_CH, 4, number of independent channels (1..16).
- CNT_W, 26, width of the divisor and counter; maximum divisor is 2^CNT_W-1.
- DEF_DIV, 100000, divisor loaded into every channel at reset; must fit in CNT_W.

Ports:
- clk_in  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ch_en  input  N_CH  per-channel enable, level-sensitive.
- sync_clr  input  1  one-cycle pulse; restarts every channel's period together.
- cfg_valid  input  1  divisor write request.
- cfg_ch  input  $clog2(N_CH) (min 1)  target channel.
- cfg_div  input  CNT_W  new divisor value.
- cfg_now  input  1  1 = apply immediately, 0 = apply at the next period boundary.
- cfg_ready  output  1  write accepted when cfg_valid && cfg_ready.
- clk_out  output  N_CH  divided clocks, registered.
- tick  output  N_CH  one-cycle pulse at the start of each period, registered.

Behaviour:
- Reset (async assert, rst_n low):
  - per channel: cnt=0, act_div=DEF_DIV, pend_flag=0, clk_out=0, tick=0.
  - cfg_ready tracks pend_flag, so it reads 1 after reset.
- Definitions: D = act_div; hi_len = (D+1)>>1. One period is D cycles; clk_out is high for hi_len cycles, then low for D-hi_len cycles.
  - D=3 gives high 2 / low 1. D=2 gives 1 / 1.
- Normal step (channel enabled, D>=1, no clear):
  - If cnt==D-1: cnt<=0, tick<=1, clk_out<=1. If pend_flag is set: act_div<=pend_div and pend_flag<=0.
  - Otherwise: cnt<=cnt+1, tick<=0, clk_out<=(cnt+1 < hi_len).
  - D=1: tick and clk_out are held at 1 every cycle.
- First period: first tick and first clk_out rise occur D cycles after reset release, enable rise, sync_clr, or an immediate load.
- D=0: channel halted. cnt is held at 0, clk_out=0, tick=0. A later load with non-zero D restarts the channel as from reset.
- ch_en low: same outputs as D=0. A pending divisor is applied at once (act_div<=pend_div, pend_flag<=0). ch_en changes take effect on the next cycle.
- cfg_ready = ~pend_flag[cfg_ch], combinational on cfg_ch. cfg_ch >= N_CH forces cfg_ready=1, and the write is dropped.
- Accepted write with cfg_now=1: act_div<=cfg_div, cnt<=0, clk_out<=0, tick<=0, pend_flag<=0.
- Accepted write with cfg_now=0: pend_div<=cfg_div, pend_flag<=1. It is applied at the next wrap.
- sync_clr, all channels:
  - cnt<=0, clk_out<=0, tick<=0.
  - Any pending divisor moves to act_div.
  - An accepted write in the same cycle goes directly into act_div, whatever cfg_now is.
- Priority: rst_n > sync_clr > immediate load > enable/halt > normal step.
- Deferred write landing on the wrap cycle: the wrap uses the old pend_div state. The new write becomes pending for the following boundary.
- Arithmetic:
  - Comparisons are unsigned in CNT_W bits; D-1 uses CNT_W bits.
  - cnt never exceeds D-1. If an immediate load shortens D below the current cnt, cnt is already cleared by the load.
- No combinational path from inputs to clk_out or tick.

Decomposition:
- Shared package freq_div_pkg holds:
  - CNT_W_DEF = 26.
  - DIV_HALT = 0.
  - Function ch_idx_w(n), returning max(1, $clog2(n)).
  - A per-channel state struct {cnt, act_div, pend_div, pend_flag}.
- Sub-module freq_div_ch: one channel containing the counter, shadow register and output regs.
- Top (freq_div_multi) contains the cfg decode, cfg_ready mux, sync_clr fan-out, and generate loop over N_CH.

Test Plan:
1. N_CH=2, DEF_DIV=6, ch_en=2'b11 after reset → both clk_out 3 high / 3 low. First tick 6 cycles after rst_n rises, then every 6 cycles.
2. Write ch0 cfg_div=5, cfg_now=0, mid-period → current period completes at 6. The next period is 5 cycles: clk_out high 3 / low 2. cfg_ready for ch0 is low until the boundary.
3. Write ch1 cfg_div=1, cfg_now=1 → next cycle clk_out[1]=0, cnt=0. The following cycle tick[1] and clk_out[1] are 1 and stay 1.
4. Write cfg_div=0 to ch0 → clk_out[0]=0 and tick[0]=0 held. Then write 2 with cfg_now=1 → toggles every cycle, first rise 2 cycles later.
5. Channels at D=6 and D=4 drifted apart, then sync_clr pulse → both ticks coincide 12 cycles after the clear (LCM).
6. rst_n low mid-period with a pending write → outputs 0 immediately (async). After release: act_div=DEF_DIV, pending value discarded, cfg_ready=1.
